// File: rtl/xor_gate_tester_pkg.sv
// Shared types for the XOR gate tester: FSM state encoding and vector-space size.
// State codes are fixed constants so external tools can decode the state register.
package xor_tester_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DRIVE  = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_CHECK  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    DRIVE  = ST_DRIVE,
    SETTLE = ST_SETTLE,
    CHECK  = ST_CHECK,
    DONE   = ST_DONE
  } state_t;

  localparam int WIDTH_DEF = 4;
  localparam int NVEC      = 1 << (2 * WIDTH_DEF);

endpackage

// File: rtl/xor_gate_tester_if.sv
// Panel/gate-side bundle of the XOR gate tester.
// The slave modport is the tester; the master modport is the panel plus gate under test.
interface xor_gate_tester_if #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 9
);
  logic                 start;
  logic                 abort;
  logic [WIDTH-1:0]     a_o;
  logic [WIDTH-1:0]     b_o;
  logic [WIDTH-1:0]     y_i;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [ERR_W-1:0]     err_cnt;
  logic [2*WIDTH-1:0]   fail_vec;
  logic                 fail_valid;

  modport slave (
    input  start, abort, y_i,
    output a_o, b_o, busy, done, pass, err_cnt, fail_vec, fail_valid
  );

  modport master (
    output start, abort, y_i,
    input  a_o, b_o, busy, done, pass, err_cnt, fail_vec, fail_valid
  );
endinterface

// File: rtl/xor_gate_tester_sync_2ff.sv
// Two-flop synchronizer for the asynchronous gate output bus.
// Each bit is synchronized independently; settle time covers inter-bit skew.
module sync_2ff #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/xor_gate_tester.sv
// Exhaustive sequencer/checker for a WIDTH-lane 2-input XOR gate.
// Drives every {A,B}, waits SETTLE_CYCLES, compares the synchronized Y, counts errors.
module xor_gate_tester
  import xor_tester_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 3,
  parameter int ERR_W         = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  xor_gate_tester_if.slave  bus
);
  localparam int VW = 2 * WIDTH;
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t             r_state;
  logic [VW-1:0]      r_vec;
  logic [3:0]         r_settle;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [ERR_W-1:0]   r_err;
  logic               r_pass;
  logic [VW-1:0]      r_fail_vec;
  logic               r_fail_valid;

  logic [WIDTH-1:0]   w_y_s;
  logic               w_mismatch;
  logic               w_last;
  logic [ERR_W-1:0]   w_err_next;

  sync_2ff #(.W(WIDTH)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (bus.y_i),
    .o_q   (w_y_s)
  );

  assign w_mismatch = (w_y_s != (r_a ^ r_b));
  assign w_last     = (r_vec == '1);
  assign w_err_next = (w_mismatch && (r_err != '1)) ? r_err + ERR_W'(1) : r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_vec        <= '0;
      r_settle     <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_err        <= '0;
      r_pass       <= 1'b0;
      r_fail_vec   <= '0;
      r_fail_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            r_err        <= '0;
            r_pass       <= 1'b0;
            r_fail_vec   <= '0;
            r_fail_valid <= 1'b0;
            r_vec        <= '0;
            r_state      <= DRIVE;
          end
        end
        DRIVE: begin
          if (bus.abort) begin
            r_pass  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_state <= DONE;
          end else begin
            r_a      <= r_vec[VW-1:WIDTH];
            r_b      <= r_vec[WIDTH-1:0];
            r_settle <= SETTLE_LOAD;
            r_state  <= SETTLE;
          end
        end
        SETTLE: begin
          if (bus.abort) begin
            r_pass  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_state <= DONE;
          end else if (r_settle == 4'd0) begin
            r_state <= CHECK;
          end else begin
            r_settle <= r_settle - 4'd1;
          end
        end
        CHECK: begin
          // Abort wins over the compare: a half-finished vector is not scored.
          if (bus.abort) begin
            r_pass  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_state <= DONE;
          end else begin
            r_err <= w_err_next;
            if (w_mismatch && !r_fail_valid) begin
              r_fail_vec   <= {r_a, r_b};
              r_fail_valid <= 1'b1;
            end
            if (w_last) begin
              r_pass  <= (w_err_next == '0);
              r_a     <= '0;
              r_b     <= '0;
              r_state <= DONE;
            end else begin
              r_vec   <= r_vec + VW'(1);
              r_state <= DRIVE;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.a_o        = r_a;
  assign bus.b_o        = r_b;
  assign bus.busy       = (r_state == DRIVE) || (r_state == SETTLE) || (r_state == CHECK);
  assign bus.done       = (r_state == DONE);
  assign bus.pass       = r_pass;
  assign bus.err_cnt    = r_err;
  assign bus.fail_vec   = r_fail_vec;
  assign bus.fail_valid = r_fail_valid;
endmodule

// File: tb/tb_xor_gate_tester.sv
// Directed bench for xor_gate_tester: table of full runs against gate models,
// plus hand-written abort, ignored-start and mid-run reset sequences.
module tb_xor_gate_tester;
  logic clk;
  logic rst_n;
  int   mode;
  int   n_tests;
  int   n_fail;

  xor_gate_tester_if #(.WIDTH(4), .ERR_W(9)) bus1 ();
  xor_gate_tester_if #(.WIDTH(4), .ERR_W(7)) bus2 ();

  xor_gate_tester #(.WIDTH(4), .SETTLE_CYCLES(3), .ERR_W(9)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  xor_gate_tester #(.WIDTH(4), .SETTLE_CYCLES(3), .ERR_W(7)) dut_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  // mode 0: ideal XOR, 1: lane 2 stuck at 0, 2: all lanes inverted
  function automatic logic [3:0] gate_model(input logic [3:0] a, input logic [3:0] b, input int m);
    logic [3:0] y;
    y = a ^ b;
    if (m == 1) y = y & 4'b1011;
    else if (m == 2) y = ~y;
    return y;
  endfunction

  assign bus1.y_i   = gate_model(bus1.a_o, bus1.b_o, mode);
  assign bus2.y_i   = gate_model(bus2.a_o, bus2.b_o, 2);
  assign bus2.start = bus1.start;
  assign bus2.abort = bus1.abort;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".busy"},       32'(bus1.busy),       32'd0);
    chk({tag, ".done"},       32'(bus1.done),       32'd0);
    chk({tag, ".pass"},       32'(bus1.pass),       32'd0);
    chk({tag, ".a_o"},        32'(bus1.a_o),        32'd0);
    chk({tag, ".b_o"},        32'(bus1.b_o),        32'd0);
    chk({tag, ".err_cnt"},    32'(bus1.err_cnt),    32'd0);
    chk({tag, ".fail_vec"},   32'(bus1.fail_vec),   32'd0);
    chk({tag, ".fail_valid"}, 32'(bus1.fail_valid), 32'd0);
  endtask

  // Pulses start; cycles = edges after the start-sampling edge until done is seen.
  // extra_at >= 0 fires a second start pulse at that cycle.
  task automatic run(input string tag, input int extra_at, output int cycles);
    @(negedge clk);
    bus1.start = 1'b1;
    @(posedge clk);
    #1;
    bus1.start = 1'b0;
    cycles = 0;
    chk({tag, ".busy_after_start"}, 32'(bus1.busy), 32'd1);
    while (!bus1.done && cycles < 2000) begin
      if (cycles == extra_at) bus1.start = 1'b1;
      @(posedge clk);
      #1;
      bus1.start = 1'b0;
      cycles++;
    end
    if (!bus1.done) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s.timeout: got no done expected done within 2000 cycles", tag);
    end
  endtask

  typedef struct {
    string      name;
    int         mode;
    int         exp_err;
    logic [7:0] exp_fv;
    logic       exp_fvld;
    logic       exp_pass;
  } vec_t;

  vec_t tbl[3];

  initial begin
    int cyc;
    int seen_done;
    n_tests = 0;
    n_fail  = 0;
    mode    = 0;
    rst_n   = 1'b0;
    bus1.start = 1'b0;
    bus1.abort = 1'b0;

    tbl[0] = '{name: "golden",   mode: 0, exp_err: 0,   exp_fv: 8'h00, exp_fvld: 1'b0, exp_pass: 1'b1};
    tbl[1] = '{name: "stuck2",   mode: 1, exp_err: 128, exp_fv: 8'h04, exp_fvld: 1'b1, exp_pass: 1'b0};
    tbl[2] = '{name: "inverted", mode: 2, exp_err: 256, exp_fv: 8'h00, exp_fvld: 1'b1, exp_pass: 0};

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      mode = tbl[i].mode;
      run(tbl[i].name, -1, cyc);
      chk({tbl[i].name, ".cycles"},     32'(cyc),             32'd1280);
      chk({tbl[i].name, ".busy"},       32'(bus1.busy),       32'd0);
      chk({tbl[i].name, ".err_cnt"},    32'(bus1.err_cnt),    32'(tbl[i].exp_err));
      chk({tbl[i].name, ".fail_vec"},   32'(bus1.fail_vec),   32'(tbl[i].exp_fv));
      chk({tbl[i].name, ".fail_valid"}, 32'(bus1.fail_valid), 32'(tbl[i].exp_fvld));
      chk({tbl[i].name, ".pass"},       32'(bus1.pass),       32'(tbl[i].exp_pass));
      chk({tbl[i].name, ".sat_done"},   32'(bus2.done),       32'd1);
      chk({tbl[i].name, ".sat_err"},    32'(bus2.err_cnt),    32'd127);
      chk({tbl[i].name, ".sat_fv"},     32'(bus2.fail_vec),   32'h00);
      chk({tbl[i].name, ".sat_pass"},   32'(bus2.pass),       32'd0);
      @(posedge clk);
      #1;
      chk({tbl[i].name, ".done_one_cycle"}, 32'(bus1.done), 32'd0);
      chk({tbl[i].name, ".pass_held"},      32'(bus1.pass), 32'(tbl[i].exp_pass));
    end

    // Second start mid-run must not restart or stretch the run.
    mode = 0;
    run("extra_start", 50, cyc);
    chk("extra_start.cycles", 32'(cyc),          32'd1280);
    chk("extra_start.pass",   32'(bus1.pass),    32'd1);
    chk("extra_start.err",    32'(bus1.err_cnt), 32'd0);
    @(posedge clk);
    #1;
    chk("extra_start.idle_busy", 32'(bus1.busy), 32'd0);

    // Abort at cycle 100 with lane 2 stuck: vectors 0..19 scored, 8 failures.
    mode = 1;
    @(negedge clk);
    bus1.start = 1'b1;
    @(posedge clk);
    #1;
    bus1.start = 1'b0;
    repeat (100) begin
      @(posedge clk);
      #1;
    end
    bus1.abort = 1'b1;
    seen_done = 0;
    for (int k = 1; k <= 3 && seen_done == 0; k++) begin
      @(posedge clk);
      #1;
      if (bus1.done) seen_done = k;
    end
    chk("abort.done_latency_ok", 32'(seen_done >= 1 && seen_done <= 2), 32'd1);
    chk("abort.pass",       32'(bus1.pass),       32'd0);
    chk("abort.a_o",        32'(bus1.a_o),        32'd0);
    chk("abort.b_o",        32'(bus1.b_o),        32'd0);
    chk("abort.busy",       32'(bus1.busy),       32'd0);
    chk("abort.err_cnt",    32'(bus1.err_cnt),    32'd8);
    chk("abort.fail_vec",   32'(bus1.fail_vec),   32'h04);
    chk("abort.fail_valid", 32'(bus1.fail_valid), 32'd1);

    // Start together with abort is ignored.
    @(negedge clk);
    bus1.start = 1'b1;
    @(posedge clk);
    #1;
    bus1.start = 1'b0;
    chk("start_with_abort.busy", 32'(bus1.busy), 32'd0);
    @(posedge clk);
    #1;
    chk("start_with_abort.busy2", 32'(bus1.busy), 32'd0);
    bus1.abort = 1'b0;

    // Reset at cycle 500 of a failing run: everything clears, no done.
    mode = 1;
    @(negedge clk);
    bus1.start = 1'b1;
    @(posedge clk);
    #1;
    bus1.start = 1'b0;
    repeat (500) begin
      @(posedge clk);
      #1;
    end
    chk("midrun.err_nonzero", 32'(bus1.err_cnt != 0), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrun_reset");
    seen_done = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bus1.done) seen_done = 1;
    end
    chk("midrun_reset.no_done", 32'(seen_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    mode = 0;
    run("after_reset", -1, cyc);
    chk("after_reset.cycles",     32'(cyc),             32'd1280);
    chk("after_reset.pass",       32'(bus1.pass),       32'd1);
    chk("after_reset.err",        32'(bus1.err_cnt),    32'd0);
    chk("after_reset.fail_valid", 32'(bus1.fail_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
